// File: rtl/mips_issue_ctrl_if.sv
// rtl/mips_issue_ctrl_if.sv - ID-stage issue/interlock signal bundle
interface mips_issue_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [31:0]      id_instr;
    logic             ex_br_taken;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_instr, ex_br_taken,
        input  pc_en, ifid_en, ifid_flush, idex_bubble, halted, stall_cnt
    );

    modport slave (
        input  id_valid, id_instr, ex_br_taken,
        output pc_en, ifid_en, ifid_flush, idex_bubble, halted, stall_cnt
    );
endinterface

// File: rtl/mips_issue_ctrl.sv
// rtl/mips_issue_ctrl.sv - MIPS32 5-stage issue, RAW interlock, flush and HLT drain control
module mips_issue_ctrl #(
    parameter int HAZ_DEPTH = 2,
    parameter int CNT_W     = 16
) (
    input logic               clk1,
    input logic               rst,
    mips_issue_ctrl_if.slave  bus
);
    localparam int DCNT_W = $clog2(HAZ_DEPTH + 2);

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    state_t              state;
    logic [DCNT_W-1:0]   dcnt;
    logic [HAZ_DEPTH-1:0] sb_v;
    logic [4:0]          sb_d [HAZ_DEPTH];
    logic [CNT_W-1:0]    cnt;

    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    logic       use_rs, use_rt, wr, is_hlt;
    logic [4:0] dest;
    logic       hit_rs, hit_rt, hazard;
    logic       run, stall_now, hlt_now, issue_wr;
    logic       unused_ok;

    assign op = bus.id_instr[31:26];
    assign rs = bus.id_instr[25:21];
    assign rt = bus.id_instr[20:16];
    assign rd = bus.id_instr[15:11];
    assign unused_ok = ^bus.id_instr[10:0];

    // Decode which registers the ID instruction reads and which one it writes
    always_comb begin
        use_rs = 1'b0;
        use_rt = 1'b0;
        wr     = 1'b0;
        is_hlt = 1'b0;
        dest   = rd;
        if (op <= 6'd5) begin
            use_rs = 1'b1;
            use_rt = 1'b1;
            wr     = 1'b1;
            dest   = rd;
        end else begin
            case (op)
                6'b001000, 6'b001010, 6'b001011, 6'b001100: begin
                    use_rs = 1'b1;
                    wr     = 1'b1;
                    dest   = rt;
                end
                6'b001001: begin
                    use_rs = 1'b1;
                    use_rt = 1'b1;
                end
                6'b001101, 6'b001110: use_rs = 1'b1;
                6'b111111:            is_hlt = 1'b1;
                default: ;
            endcase
        end
    end

    // Compare both sources against every in-flight destination not yet written back
    always_comb begin
        hit_rs = 1'b0;
        hit_rt = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (sb_v[i] && (sb_d[i] == rs)) hit_rs = 1'b1;
            if (sb_v[i] && (sb_d[i] == rt)) hit_rt = 1'b1;
        end
    end

    // R0 is hardwired, so it never creates a dependence
    assign hazard = bus.id_valid &
                    ((use_rs & (rs != 5'd0) & hit_rs) |
                     (use_rt & (rt != 5'd0) & hit_rt));

    // A taken branch kills the ID slot, so it overrides both stall and HLT
    assign run       = (state == RUN);
    assign stall_now = run & ~bus.ex_br_taken & hazard;
    assign hlt_now   = run & ~bus.ex_br_taken & ~hazard & bus.id_valid & is_hlt;
    assign issue_wr  = run & ~bus.ex_br_taken & ~hazard & bus.id_valid & wr & (dest != 5'd0);

    // Same-cycle pipeline control decided from state and the ID instruction
    always_comb begin
        bus.pc_en       = 1'b1;
        bus.ifid_en     = 1'b1;
        bus.ifid_flush  = 1'b0;
        bus.idex_bubble = 1'b0;
        bus.halted      = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (bus.ex_br_taken) begin
                        bus.ifid_flush  = 1'b1;
                        bus.idex_bubble = 1'b1;
                    end else if (hazard) begin
                        bus.pc_en       = 1'b0;
                        bus.ifid_en     = 1'b0;
                        bus.idex_bubble = 1'b1;
                    end else if (hlt_now) begin
                        bus.pc_en   = 1'b0;
                        bus.ifid_en = 1'b0;
                    end
                end
                DRAIN: begin
                    bus.pc_en       = 1'b0;
                    bus.ifid_en     = 1'b0;
                    bus.idex_bubble = 1'b1;
                end
                default: begin
                    bus.pc_en       = 1'b0;
                    bus.ifid_en     = 1'b0;
                    bus.idex_bubble = 1'b1;
                    bus.halted      = 1'b1;
                end
            endcase
        end
    end

    assign bus.stall_cnt = cnt;

    // Scoreboard shift, stall counter and RUN/DRAIN/HALT sequencing
    always_ff @(posedge clk1) begin
        if (rst) begin
            state <= RUN;
            dcnt  <= '0;
            sb_v  <= '0;
            cnt   <= '0;
            for (int i = 0; i < HAZ_DEPTH; i++) sb_d[i] <= 5'd0;
        end else begin
            sb_v[0] <= issue_wr;
            sb_d[0] <= dest;
            for (int i = 1; i < HAZ_DEPTH; i++) begin
                sb_v[i] <= sb_v[i-1];
                sb_d[i] <= sb_d[i-1];
            end
            if (stall_now && (cnt != {CNT_W{1'b1}})) cnt <= cnt + 1'b1;
            case (state)
                RUN: begin
                    // The HLT issue cycle is the first of HAZ_DEPTH+1 drain cycles
                    if (hlt_now) begin
                        state <= DRAIN;
                        dcnt  <= DCNT_W'(HAZ_DEPTH);
                    end
                end
                DRAIN: begin
                    if (dcnt <= DCNT_W'(1)) begin
                        state <= HALT;
                        dcnt  <= '0;
                    end else begin
                        dcnt <= dcnt - 1'b1;
                    end
                end
                HALT:    state <= HALT;
                default: state <= RUN;
            endcase
        end
    end
endmodule
